// File: rtl/zmips_data_ram.sv
// Purpose: single-port, byte-addressed word RAM for the ZMIPS d_* bus, with byte-lane writes and programmable wait states.
// Latency: a request captured in IDLE completes WAIT_STATES cycles later, with a one-cycle ready (and err) pulse in DONE.
// Backpressure: busy is high from capture until the FSM returns to IDLE; requests presented while busy are ignored.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous reset, active low
//   addr     byte address; word index = addr >> log2(WIDTH/8)
//   wr_data  write data
//   be       byte-lane write enables (bit i covers bits [8i+7:8i]); ignored on reads
//   wr, rd   write / read request, sampled only in IDLE
//   rd_data  registered read data; meaningful while ready=1 and err=0
//   ready    one-cycle completion pulse
//   err      access fault, qualified by ready
//   busy     access in flight
module zmips_data_ram #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] be,
  input  logic               wr,
  input  logic               rd,
  output logic [WIDTH-1:0]   rd_data,
  output logic               ready,
  output logic               err,
  output logic               busy
);

  localparam int unsigned NB = WIDTH / 8;
  localparam int unsigned LB = (NB > 1) ? $clog2(NB) : 0;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] ALIGN_MASK = 32'(NB - 1);
  localparam logic [31:0] DEPTH_W    = 32'(DEPTH);
  localparam logic [7:0]  WS8        = 8'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Storage (contents are deliberately not reset)
  logic [WIDTH-1:0] r_mem [DEPTH];

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_nxt;

  // Captured request
  logic [31:0]      r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [NB-1:0]    r_be;
  logic             r_rd;
  logic             r_wr;

  logic             r_err;
  logic [WIDTH-1:0] r_rdata;

  logic             w_capture;
  logic             w_enter_done;

  // With zero wait states DONE is entered on the capture edge itself, so the
  // operands come straight from the inputs; otherwise from the captured copy.
  logic [31:0]      w_op_addr;
  logic [WIDTH-1:0] w_op_wdata;
  logic [NB-1:0]    w_op_be;
  logic             w_op_rd;
  logic             w_op_wr;

  logic [31:0]      w_word;
  logic [AW-1:0]    w_idx;
  logic             w_misalign;
  logic             w_oob;
  logic             w_conflict;
  logic             w_fault;
  logic             w_commit;

  assign w_op_addr  = (r_state == S_IDLE) ? addr    : r_addr;
  assign w_op_wdata = (r_state == S_IDLE) ? wr_data : r_wdata;
  assign w_op_be    = (r_state == S_IDLE) ? be      : r_be;
  assign w_op_rd    = (r_state == S_IDLE) ? rd      : r_rd;
  assign w_op_wr    = (r_state == S_IDLE) ? wr      : r_wr;

  assign w_word     = w_op_addr >> LB;
  assign w_idx      = w_word[AW-1:0];
  assign w_misalign = |(w_op_addr & ALIGN_MASK);
  assign w_oob      = (w_word >= DEPTH_W);
  assign w_conflict = w_op_rd & w_op_wr;
  assign w_fault    = w_misalign | w_oob | w_conflict;

  // The array has no reset path, so a commit must be blocked explicitly
  // while rst is low.
  assign w_commit   = w_enter_done & rst & w_op_wr & ~w_fault;

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_capture    = 1'b0;
    w_enter_done = 1'b0;
    ready        = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (rd | wr) begin
          w_capture = 1'b1;
          if (WAIT_STATES > 0) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = WS8;
          end else begin
            w_state_nxt  = S_DONE;
            w_enter_done = 1'b1;
          end
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 8'd1;
        if (r_cnt == 8'd1) begin
          w_state_nxt  = S_DONE;
          w_enter_done = 1'b1;
        end
      end
      S_DONE: begin
        ready       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Request capture and completion status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= 32'd0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_capture) begin
        r_addr  <= addr;
        r_wdata <= wr_data;
        r_be    <= be;
        r_rd    <= rd;
        r_wr    <= wr;
      end
      if (w_enter_done) begin
        r_err <= w_fault;
        if (w_fault) begin
          r_rdata <= '0;
        end else if (w_op_rd) begin
          r_rdata <= r_mem[w_idx];
        end
      end
    end
  end

  // Byte-lane write into the array
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (w_op_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_op_wdata[8*i +: 8];
        end
      end
    end
  end

  assign rd_data = r_rdata;
  assign err     = (r_state == S_DONE) & r_err;

endmodule
